// File: rtl/uart_cmd_parser_if.sv
// Byte stream in, FIFO pushes and status out, for the
// UART command parser.
interface uart_cmd_parser_if #(
  parameter int MAX_N = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;
  logic             fifo_full;
  logic [3:0]       N;
  logic             start;
  logic [7:0]       wr_data;
  logic [MAX_N-1:0] push_row;
  logic             push_vec;
  logic             clr;
  logic             ready;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output rx_data, rx_valid, busy, fifo_full,
    input  N, start, wr_data, push_row,
    input  push_vec, clr, ready, err, err_code
  );

  modport slave (
    input  rx_data, rx_valid, busy, fifo_full,
    output N, start, wr_data, push_row,
    output push_vec, clr, ready, err, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame hunter/decoder between UART RX and the
// matrix-vector engine: sets N, fills FIFOs, starts runs.
module uart_cmd_parser #(
  parameter int         MAX_N = 8,
  parameter logic [7:0] SOF   = 8'hFE,
  parameter logic [7:0] EOF   = 8'hEF
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_parser_if.slave bus
);
  localparam logic [7:0] CMD_SETN  = 8'h01;
  localparam logic [7:0] CMD_START = 8'h03;
  localparam logic [7:0] CMD_LOAD  = 8'h04;
  localparam logic [7:0] MAXN8     = 8'(MAX_N);
  localparam logic [1:0] BAD_CMD   = 2'd0;
  localparam logic [1:0] BAD_EOF   = 2'd1;
  localparam logic [1:0] NOT_READY = 2'd2;
  localparam logic [1:0] OVERFLOW  = 2'd3;
  localparam logic [MAX_N-1:0] ONE = MAX_N'(1);

  typedef enum logic [2:0] {
    IDLE, GET_LEN, GET_CMD, GET_PAY, GET_EOF
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       rem_q, rem_d;
  logic [7:0]       pay_q, pay_d;
  logic [3:0]       row_q, row_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       n_q, n_d;
  logic             ready_q, ready_d;
  logic             start_q, start_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       wr_q, wr_d;
  logic [MAX_N-1:0] prow_q, prow_d;
  logic             pvec_q, pvec_d;

  logic [7:0] n8;
  logic [7:0] load_len;
  logic       cmd_ok;
  logic       fail;
  logic [1:0] fcode;

  assign n8       = {4'd0, n_q};
  assign load_len = n8 * n8 + n8 + 8'd1;

  always_comb begin
    cmd_ok = 1'b0;
    unique case (1'b1)
      bus.rx_data == CMD_SETN:  cmd_ok = len_q == 8'd2;
      bus.rx_data == CMD_START: cmd_ok = len_q == 8'd1;
      bus.rx_data == CMD_LOAD:
        cmd_ok = (len_q == load_len) && (n_q != 4'd0);
      default:                  cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cmd_d   = cmd_q;
    rem_d   = rem_q;
    pay_d   = pay_q;
    row_d   = row_q;
    col_d   = col_q;
    n_d     = n_q;
    ready_d = ready_q;
    start_d = 1'b0;
    clr_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    wr_d    = wr_q;
    prow_d  = '0;
    pvec_d  = 1'b0;
    fail    = 1'b0;
    fcode   = BAD_CMD;
    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == SOF) state_d = GET_LEN;
        end
        GET_LEN: begin
          len_d = bus.rx_data;
          if (bus.rx_data == 8'd0) fail = 1'b1;
          else state_d = GET_CMD;
        end
        GET_CMD: begin
          cmd_d = bus.rx_data;
          rem_d = len_q - 8'd1;
          row_d = 4'd0;
          col_d = 4'd0;
          if (!cmd_ok) begin
            fail = 1'b1;
          end else if (bus.busy) begin
            fail  = 1'b1;
            fcode = NOT_READY;
          end else begin
            state_d = (len_q == 8'd1) ? GET_EOF : GET_PAY;
            if (bus.rx_data == CMD_LOAD) begin
              clr_d   = 1'b1;
              ready_d = 1'b0;
            end
          end
        end
        GET_PAY: begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = GET_EOF;
          if (cmd_q != CMD_LOAD) begin
            pay_d = bus.rx_data;
          end else if (bus.fifo_full) begin
            fail  = 1'b1;
            fcode = OVERFLOW;
          end else begin
            wr_d = bus.rx_data;
            // row_q == N marks the vector tail of the payload
            if (row_q == n_q) begin
              pvec_d = 1'b1;
            end else begin
              prow_d = ONE << row_q;
              if (col_q == n_q - 4'd1) begin
                col_d = 4'd0;
                row_d = row_q + 4'd1;
              end else begin
                col_d = col_q + 4'd1;
              end
            end
          end
        end
        GET_EOF: begin
          state_d = IDLE;
          if (bus.rx_data != EOF) begin
            fail  = 1'b1;
            fcode = BAD_EOF;
          end else begin
            unique case (1'b1)
              cmd_q == CMD_SETN: begin
                if (pay_q >= 8'd2 && pay_q <= MAXN8) begin
                  n_d     = pay_q[3:0];
                  ready_d = 1'b0;
                  clr_d   = 1'b1;
                end else begin
                  fail = 1'b1;
                end
              end
              cmd_q == CMD_LOAD: ready_d = 1'b1;
              default: begin
                if (ready_q) begin
                  start_d = 1'b1;
                  ready_d = 1'b0;
                end else begin
                  fail  = 1'b1;
                  fcode = NOT_READY;
                end
              end
            endcase
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (fail) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = fcode;
      clr_d   = 1'b1;
      ready_d = 1'b0;
      prow_d  = '0;
      pvec_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cmd_q   <= '0;
      rem_q   <= '0;
      pay_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      n_q     <= '0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      wr_q    <= '0;
      prow_q  <= '0;
      pvec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cmd_q   <= cmd_d;
      rem_q   <= rem_d;
      pay_q   <= pay_d;
      row_q   <= row_d;
      col_q   <= col_d;
      n_q     <= n_d;
      ready_q <= ready_d;
      start_q <= start_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      code_q  <= code_d;
      wr_q    <= wr_d;
      prow_q  <= prow_d;
      pvec_q  <= pvec_d;
    end
  end

  assign bus.N        = n_q;
  assign bus.ready    = ready_q;
  assign bus.start    = start_q;
  assign bus.clr      = clr_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;
  assign bus.wr_data  = wr_q;
  assign bus.push_row = prow_q;
  assign bus.push_vec = pvec_q;
endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser between the UART receiver and the matrix-vector processor FSM. Hunts for framed commands in the RX byte stream, programs the matrix size N, routes matrix rows into per-row FIFOs and vector elements into the vector FIFO, and issues the one-cycle `start` that launches a computation. Flags malformed frames and flushes partially loaded FIFOs on error.

## Interface
- `MAX_N`, 8: maximum matrix dimension, which is also the number of row FIFOs.
- `SOF`, 8'hFE: start-of-frame byte.
- `EOF`, 8'hEF: end-of-frame byte.
- `clk`  in  1  system clock; all logic rises on its posedge.
- `rst`  in  1  reset, synchronous and active-low.
- `rx_data`  in  8  received byte; valid only while `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe per received byte; may be high on consecutive cycles.
- `busy`  in  1  processor FSM is not idle.
- `fifo_full`  in  1  OR of all row and vector FIFO full flags.
- `N`  out  4  programmed matrix size; 0 means unset.
- `start`  out  1  one-cycle pulse that launches a computation.
- `wr_data`  out  8  data byte to the FIFOs.
- `push_row`  out  MAX_N  one-hot push, one bit per row FIFO.
- `push_vec`  out  1  vector FIFO push.
- `clr`  out  1  one-cycle flush of all row and vector FIFOs.
- `ready`  out  1  a complete matrix and vector are loaded for the current N.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error cause, valid while `err`=1: 0 BAD_CMD, 1 BAD_EOF, 2 NOT_READY, 3 OVERFLOW.

## Operation
- Frame format: `SOF`, LEN, CMD, payload of LEN-1 bytes, `EOF`. LEN counts CMD plus the payload.
- Commands:
  - 0x01 SET_N: LEN=2, payload is N. N must be in 2..MAX_N.
  - 0x03 START: LEN=1.
  - 0x04 LOAD: LEN=1+N*N+N.
- States: IDLE, GET_LEN, GET_CMD, GET_PAY, GET_EOF. A state advances only on `rx_valid`.
- IDLE: any byte other than `SOF` is discarded. `SOF` moves to GET_LEN.
- GET_LEN: latch LEN. LEN=0 raises BAD_CMD.
- GET_CMD: validate the command.
  - Unknown CMD, or LEN mismatch for the CMD → BAD_CMD.
  - LOAD with N=0 → BAD_CMD.
  - `busy`=1 with any CMD → NOT_READY.
  - Otherwise go to GET_PAY, or to GET_EOF when LEN=1.
  - A LOAD accepted here pulses `clr` and clears `ready`, so the new load starts from empty FIFOs.
- GET_PAY for SET_N: the byte is held and range-checked at EOF. Out-of-range → BAD_CMD at EOF.
- GET_PAY for LOAD:
  - The first N*N bytes are row-major matrix data. Each goes to `push_row[row]`; the column counter wraps at N-1 and then increments row.
  - The next N bytes go to `push_vec`.
  - A push attempted while `fifo_full`=1 → OVERFLOW.
- GET_EOF:
  - A byte other than `EOF` → BAD_EOF.
  - `EOF` executes the command:
    - SET_N: update `N`, clear `ready`, pulse `clr`.
    - LOAD: set `ready`.
    - START: if `ready`=1, pulse `start` and clear `ready`; else NOT_READY.
- Any error: pulse `err` with its code, pulse `clr`, clear `ready`, return to IDLE. No push is issued for the offending byte. The next `SOF` resynchronizes the parser; a 0xFE inside discarded data may cause a false start, which is caught later by the length and EOF checks.
- Reset (`rst`=0 at a clock edge) abandons any frame in progress. FIFOs are not flushed by this block; system reset clears them.

## Timing
- Reset values: state IDLE, `N`=0, `ready`=0, `start`=0, `wr_data`=0, `push_row`=0, `push_vec`=0, `clr`=0, `err`=0, `err_code`=0.
- All outputs are registered.
- A push, `start`, `err`, or `clr` is asserted in the cycle after the `rx_valid` that causes it, for exactly one cycle. `wr_data` is valid in that same cycle.
- `N` and `ready` update one cycle after the causing `rx_valid`.
- Back-to-back `rx_valid` is supported at full rate: one push per cycle, no bubbles.
- At most one of `push_row`/`push_vec` is high in any cycle.
- `clr` and a push are never high in the same cycle.
- `busy` and `fifo_full` are sampled in the same cycle as `rx_valid`.

## Test plan
- Set N, then load (N=2). Send FE 02 01 02 EF, then FE 07 04 11 12 21 22 A1 A2 EF. Required:
  - `N`=2.
  - `clr` pulse on the LOAD CMD byte.
  - Pushes in order: row0 11,12; row1 21,22; vec A1,A2.
  - `ready`=1 after EF.
- Start: send FE 01 03 EF. Required: `start` pulse one cycle after EF, `ready`=0. Resend the same frame → `err`, code 2.
- Bad EOF: a LOAD frame whose last byte is 0x00 instead of EF. Required: `err` code 1, `clr` pulse, `ready`=0. The next valid frame parses correctly.
- Range and length: FE 02 01 09 EF → code 0, `N` unchanged. FE 05 04 ... with N=2 → code 0 at the CMD byte, with no pushes.
- Busy and overflow:
  - `busy`=1 during a START CMD byte → code 2.
  - `fifo_full`=1 at the third payload byte → code 3; exactly two pushes are observed, then `clr`.
- Reset mid-frame: assert `rst`=0 after 3 payload bytes. Required: all outputs at reset values and `N`=0. Leading junk 00 55 then a valid frame is accepted.
